// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: operand sequencer in front of a fixed-latency signed multiplier.
// Queues operand pairs from a valid/ready source, issues them one at a time on
// mlier/mcand/start, waits for the multiplier's valid (or a timeout), and hands
// each product to a valid/ready consumer.
// Ports:
//   clock, reset            clock and synchronous active-low reset
//   in_valid/in_ready/in_a/in_b   operand pair input handshake
//   mlier/mcand/start       registered drive to the multiplier
//   valid/prodt             multiplier result (valid may be a level or a pulse)
//   out_valid/out_ready/out_prod/out_err   result output handshake
//   busy                    operation in flight or operands queued
module mult_issue_ctrl #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 40
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic [WIDTH-1:0]   mlier,
   output logic [WIDTH-1:0]   mcand,
   output logic               start,
   input  logic               valid,
   input  logic [2*WIDTH-1:0] prodt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic               out_err,
   output logic               busy
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TCNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    fifo_a_q [FIFO_DEPTH];
   logic [WIDTH-1:0]    fifo_a_d [FIFO_DEPTH];
   logic [WIDTH-1:0]    fifo_b_q [FIFO_DEPTH];
   logic [WIDTH-1:0]    fifo_b_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic                valid_q;
   logic [WIDTH-1:0]    mlier_q, mlier_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic                start_q, start_d;
   logic                out_valid_q, out_valid_d;
   logic [PW-1:0]       out_prod_q, out_prod_d;
   logic                out_err_q, out_err_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                push;
   logic                pop;
   logic                vld_rise;

   // A held valid level counts once: only its rising edge completes an op.
   assign vld_rise = valid & ~valid_q;
   assign push     = in_valid & in_ready_q;
   assign pop      = (state_q == ST_IDLE) && (count_q != '0);

   // Operand FIFO bookkeeping; push and pop may coincide.
   always_comb begin
      fifo_a_d = fifo_a_q;
      fifo_b_d = fifo_b_q;
      if (push) begin
         fifo_a_d[wr_ptr_q] = in_a;
         fifo_b_d[wr_ptr_q] = in_b;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Issue FSM: next state and registered multiplier/result outputs.
   always_comb begin
      state_d     = state_q;
      mlier_d     = mlier_q;
      mcand_d     = mcand_q;
      start_d     = start_q;
      tcnt_d      = tcnt_q;
      out_valid_d = out_valid_q;
      out_prod_d  = out_prod_q;
      out_err_d   = out_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               mlier_d = fifo_a_q[rd_ptr_q];
               mcand_d = fifo_b_q[rd_ptr_q];
               start_d = 1'b1;
               tcnt_d  = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            // A result arriving on the timeout cycle still counts as good.
            if (vld_rise) begin
               out_prod_d  = prodt;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               start_d     = 1'b0;
               state_d     = ST_DRAIN;
            end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
               out_prod_d  = '0;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               start_d     = 1'b0;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_GAP;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
      busy_d     = (state_d != ST_IDLE) || (count_d != '0);
   end

   // Control and output registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tcnt_q      <= '0;
         valid_q     <= 1'b0;
         mlier_q     <= '0;
         mcand_q     <= '0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_prod_q  <= '0;
         out_err_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tcnt_q      <= tcnt_d;
         valid_q     <= valid;
         mlier_q     <= mlier_d;
         mcand_q     <= mcand_d;
         start_q     <= start_d;
         out_valid_q <= out_valid_d;
         out_prod_q  <= out_prod_d;
         out_err_q   <= out_err_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   // FIFO storage needs no reset: entries are only read after being written.
   always_ff @(posedge clock) begin
      fifo_a_q <= fifo_a_d;
      fifo_b_q <= fifo_b_d;
   end

   assign in_ready  = in_ready_q;
   assign mlier     = mlier_q;
   assign mcand     = mcand_q;
   assign start     = start_q;
   assign out_valid = out_valid_q;
   assign out_prod  = out_prod_q;
   assign out_err   = out_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: drives mult_issue_ctrl with directed and random operand
// traffic, models the multiplier (latency LAT, optional silence to force a
// timeout) and checks every output each cycle against a timeline model.
module tb_mult_issue_ctrl;

   localparam int LAT     = 33;
   localparam int TIMEOUT = 40;
   localparam int DEPTH   = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] mlier;
   logic [31:0] mcand;
   logic        start;
   logic        valid;
   logic [63:0] prodt;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_prod;
   logic        out_err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   bit mute      = 1'b0;
   bit force_vld = 1'b0;
   bit rand_ordy = 1'b0;
   bit rand_mute = 1'b0;

   logic [63:0] got_prod[$];
   logic        got_err[$];

   mult_issue_ctrl #(.WIDTH(32), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mlier(mlier), .mcand(mcand), .start(start),
      .valid(valid), .prodt(prodt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_prod(out_prod), .out_err(out_err), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      longint x;
      longint y;
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and per-cycle compare ----------------
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   bit          op_on, res_on, gap_on, cur_mute;
   int          run;
   logic [31:0] cur_a, cur_b, last_a, last_b;
   logic [63:0] exp_prod;
   logic        exp_err;
   bit          s_rst = 1'b0, s_acc, s_ordy, s_ov, s_mute;
   logic [31:0] s_a, s_b;
   logic [63:0] s_prod;
   logic        s_err;

   always @(negedge clock) begin : model
      bit prev_idle;
      bit had;
      bit fire;
      if (!s_rst) begin
         q_a.delete(); q_b.delete();
         op_on = 0; res_on = 0; gap_on = 0; run = 0;
         last_a = '0; last_b = '0;
      end else begin
         prev_idle = !op_on && !res_on && !gap_on;
         had       = (q_a.size() > 0);
         if (s_ov && s_ordy) begin
            got_prod.push_back(s_prod);
            got_err.push_back(s_err);
         end
         if (gap_on) gap_on = 0;
         if (res_on && s_ordy) begin
            res_on = 0;
            gap_on = 1;
         end
         if (op_on) begin
            run++;
            if ((!cur_mute && run == LAT + 1) || run == TIMEOUT + 1) begin
               op_on  = 0;
               res_on = 1;
            end
         end
         if (prev_idle && had) begin
            cur_a    = q_a.pop_front();
            cur_b    = q_b.pop_front();
            cur_mute = s_mute;
            op_on    = 1;
            run      = 1;
            last_a   = cur_a;
            last_b   = cur_b;
            exp_prod = cur_mute ? 64'd0 : smul(cur_a, cur_b);
            exp_err  = cur_mute;
         end
         if (s_acc) begin
            q_a.push_back(s_a);
            q_b.push_back(s_b);
         end
      end
      chk("start", start, op_on);
      chk("in_ready", in_ready, q_a.size() < DEPTH);
      chk("out_valid", out_valid, res_on);
      chk("busy", busy, op_on || res_on || gap_on || q_a.size() != 0);
      chk("mlier", mlier, last_a);
      chk("mcand", mcand, last_b);
      if (res_on) begin
         chk("out_prod", out_prod, exp_prod);
         chk("out_err", out_err, exp_err);
      end
      // multiplier model: one-cycle valid pulse LAT cycles into the operation
      fire  = op_on && !cur_mute && run == LAT;
      valid = fire || force_vld;
      prodt = fire ? smul(cur_a, cur_b) : {$urandom(), $urandom()};
      s_rst  = reset;
      s_acc  = in_valid && in_ready;
      s_a    = in_a;
      s_b    = in_b;
      s_ordy = out_ready;
      s_ov   = out_valid;
      s_prod = out_prod;
      s_err  = out_err;
      s_mute = mute;
   end

   // Random consumer back-pressure and multiplier silence.
   always @(posedge clock) begin
      if (rand_ordy || rand_mute) begin
         #1;
         if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
         if (rand_mute) mute = ($urandom_range(0, 7) == 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n;
      bit acc;
      n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 3000);
      in_valid = 1'b0;
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready never high");
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      chk("wait_idle", busy, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   logic [31:0] ta [7];
   logic [31:0] tb [7];

   initial begin
      int k;
      int idx;
      int base;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      valid     = 1'b0;
      prodt     = '0;

      // 1: reset values
      repeat (2) tick();
      chk("rst_start", start, 1'b0);
      chk("rst_mlier", mlier, 32'd0);
      chk("rst_mcand", mcand, 32'd0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_prod", out_prod, 64'd0);
      chk("rst_out_err", out_err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;
      tick();

      // 2: single op, latency from accept edge to out_valid
      send(32'd3, 32'd5);
      chk("t2_start_pre", start, 1'b0);
      tick();
      chk("t2_start", start, 1'b1);
      chk("t2_mlier", mlier, 32'd3);
      chk("t2_mcand", mcand, 32'd5);
      k = 1;
      while (!out_valid && k < 200) begin
         tick();
         k++;
      end
      chk("t2_latency", 64'(k), 64'd34);
      chk("t2_prod", out_prod, 64'd15);
      chk("t2_err", out_err, 1'b0);
      wait_idle(100);

      // 3: signed products in order
      send(32'hFFFF_FFF9, 32'd6);
      send(32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(400);
      chk("t3_count", 64'(got_prod.size()), 64'd3);
      if (got_prod.size() == 3) begin
         chk("t3_first", got_prod[0], 64'd15);
         chk("t3_neg42", got_prod[1], 64'hFFFF_FFFF_FFFF_FFD6);
         chk("t3_pos2p31", got_prod[2], 64'h0000_0000_8000_0000);
         chk("t3_err", 64'(got_err[1] | got_err[2]), 64'd0);
      end

      // 4: back-pressure fills the FIFO, then drain in order
      for (int i = 0; i < 7; i++) begin
         ta[i] = pick();
         tb[i] = pick();
      end
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         bit acc;
         in_valid = (idx < 7);
         in_a = (idx < 7) ? ta[idx] : 32'd0;
         in_b = (idx < 7) ? tb[idx] : 32'd0;
         acc = in_ready && in_valid;
         tick();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("t4_accepted", 64'(idx), 64'd5);
      chk("t4_in_ready", in_ready, 1'b0);
      base = got_prod.size();
      rand_ordy = 1'b1;
      wait_idle(3000);
      rand_ordy = 1'b0;
      tick();
      out_ready = 1'b1;
      chk("t4_results", 64'(got_prod.size() - base), 64'd5);
      if (got_prod.size() == base + 5)
         for (int i = 0; i < 5; i++) chk("t4_order", got_prod[base + i], smul(ta[i], tb[i]));

      // 5: silent multiplier -> timeout error, next op still completes
      mute = 1'b1;
      send(32'd9, 32'd9);
      tick();
      mute = 1'b0;
      send(32'd4, 32'hFFFF_FFFD);
      wait_idle(400);
      base = got_prod.size();
      chk("t5_count", 64'(base), 64'd10);
      if (base == 10) begin
         chk("t5_to_prod", got_prod[8], 64'd0);
         chk("t5_to_err", 64'(got_err[8]), 64'd1);
         chk("t5_next_prod", got_prod[9], 64'hFFFF_FFFF_FFFF_FFF4);
         chk("t5_next_err", 64'(got_err[9]), 64'd0);
      end

      // 6: reset mid-operation discards everything; stray valid ignored
      send(32'd11, 32'd12);
      send(32'd13, 32'd14);
      send(32'd15, 32'd16);
      repeat (5) tick();
      chk("t6_pre_start", start, 1'b1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t6_start", start, 1'b0);
      chk("t6_out_valid", out_valid, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_in_ready", in_ready, 1'b1);
      repeat (3) tick();
      force_vld = 1'b1;
      tick();
      force_vld = 1'b0;
      repeat (45) tick();
      chk("t6_no_result", 64'(got_prod.size()), 64'(base));
      chk("t6_out_valid_late", out_valid, 1'b0);

      // random traffic with back-pressure and occasional timeouts
      rand_ordy = 1'b1;
      rand_mute = 1'b1;
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 5)) tick();
         send(pick(), pick());
      end
      wait_idle(8000);
      rand_ordy = 1'b0;
      rand_mute = 1'b0;
      tick();
      out_ready = 1'b1;
      mute = 1'b0;
      chk("rand_count", 64'(got_prod.size()), 64'(base + 25));
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
